// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the instruction sequencer and its execute decoder:
//   - state_t     : sequencer state encodings (also visible on StateDbg)
//   - OP_*        : 4-bit opcodes as held in the instruction register
//   - ALU_*       : AluOp encodings seen by the accumulator datapath
//   - exec_ctl_t  : bundle of the EXEC-cycle control strobes
//   - is_operand_op() : true for opcodes that read the operand bus
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH  = 3'b001,
    ST_LATCH  = 3'b010,
    ST_DECODE = 3'b011,
    ST_EXEC   = 3'b100,
    ST_HALT   = 3'b101
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  // 2'b11 is reserved and never produced by the decoder.
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef struct packed {
    logic       enable_ir;
    logic       pc_load;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       out_latch;
    logic       is_halt;
  } exec_ctl_t;

  localparam exec_ctl_t EXEC_NONE = '0;

  // Opcodes whose operand field must be driven onto the operand bus.
  function automatic logic is_operand_op(input logic [3:0] opcode);
    return (opcode == OP_LDI) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
           (opcode == OP_JMP) || (opcode == OP_JZ);
  endfunction

endpackage

// File: rtl/exec_decode.sv
// ---------------------------------------------------------------------------
// exec_decode
// Purely combinational opcode decoder. Produces the strobes the sequencer
// will register into its EXEC cycle.
// Ports:
//   opcode    in  4  opcode from the instruction register
//   acc_zero  in  1  accumulator-is-zero flag (only matters for JZ)
//   enable_ir out 1  drive stored operand onto the operand bus
//   pc_load   out 1  load program counter from operand bus
//   acc_load  out 1  accumulator load
//   alu_op    out 2  ALU function for the accumulator load
//   out_latch out 1  output port load
//   is_halt   out 1  opcode is HLT
// ---------------------------------------------------------------------------
module exec_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output logic       enable_ir,
  output logic       pc_load,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       out_latch,
  output logic       is_halt
);

  // Operand bus enable depends only on the opcode, so JZ drives the bus
  // whether or not the branch is taken. Unlisted opcodes 0x7..0xE fall to
  // the default and behave exactly like NOP.
  always_comb begin
    enable_ir = is_operand_op(opcode);
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    alu_op    = ALU_PASS;
    out_latch = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_LDI: begin
        acc_load = 1'b1;
        alu_op   = ALU_PASS;
      end
      OP_ADD: begin
        acc_load = 1'b1;
        alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        acc_load = 1'b1;
        alu_op   = ALU_SUB;
      end
      OP_JMP: pc_load   = 1'b1;
      OP_JZ:  pc_load   = acc_zero;
      OP_OUT: out_latch = 1'b1;
      OP_HLT: is_halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Fetch/latch/decode/execute control sequencer for the 4-bit datapath.
// Decides when the instruction register is loaded, cleared and read, and
// issues program-counter, memory, accumulator and output strobes.
// Parameters:
//   MEM_WAIT  extra FETCH wait cycles for program memory (0..7)
// Ports:
//   MainClock      in  1  system clock, rising edge active
//   ResetN         in  1  asynchronous active-low reset
//   Run            in  1  start/continue execution (sampled in IDLE, EXEC)
//   ToInstr        in  4  opcode from the instruction register
//   AccZero        in  1  accumulator-is-zero flag
//   MemRead        out 1  program memory read strobe
//   PcInc          out 1  increment program counter
//   PcLoad         out 1  load program counter from operand bus
//   LatchInstrReg  out 1  instruction register load (gated with MainClock)
//   ClearInstrReg  out 1  instruction register clear
//   EnableInstrReg out 1  drive stored operand onto the operand bus
//   AccLoad        out 1  accumulator load
//   AluOp          out 2  00 pass, 01 add, 10 sub
//   OutLatch       out 1  output port load
//   Halted         out 1  high in HALT
//   StateDbg       out 3  current state encoding
// ---------------------------------------------------------------------------
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       MainClock,
  input  logic       ResetN,
  input  logic       Run,
  input  logic [3:0] ToInstr,
  input  logic       AccZero,
  output logic       MemRead,
  output logic       PcInc,
  output logic       PcLoad,
  output logic       LatchInstrReg,
  output logic       ClearInstrReg,
  output logic       EnableInstrReg,
  output logic       AccLoad,
  output logic [1:0] AluOp,
  output logic       OutLatch,
  output logic       Halted,
  output logic [2:0] StateDbg
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;
  logic       halt_pending;
  exec_ctl_t  dec_ctl;

  exec_decode u_exec_decode (
    .opcode    (ToInstr),
    .acc_zero  (AccZero),
    .enable_ir (dec_ctl.enable_ir),
    .pc_load   (dec_ctl.pc_load),
    .acc_load  (dec_ctl.acc_load),
    .alu_op    (dec_ctl.alu_op),
    .out_latch (dec_ctl.out_latch),
    .is_halt   (dec_ctl.is_halt)
  );

  // Next-state logic. FETCH holds until the wait counter reaches zero, so it
  // lasts WAIT_INIT+1 cycles. Run is only consulted in IDLE and EXEC, which
  // means dropping it mid-instruction lets the instruction finish. HALT is
  // a trap that only reset leaves.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (Run) state_next = ST_FETCH;
      ST_FETCH:  if (wait_cnt == 3'd0) state_next = ST_LATCH;
      ST_LATCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (halt_pending) state_next = ST_HALT;
        else if (Run)     state_next = ST_FETCH;
        else              state_next = ST_IDLE;
      end
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, wait counter and every strobe are registered. Outputs are
  // computed from state_next so each flop already holds the value for the
  // state being entered; this keeps LatchInstrReg (which gates a clock),
  // ClearInstrReg and EnableInstrReg free of any decode logic after the
  // flop. The EXEC strobes are captured from the decoder on the
  // DECODE->EXEC edge, when ToInstr has settled. The wait counter reloads
  // on every FETCH entry and only counts down while nonzero, so it can
  // never wrap.
  always_ff @(posedge MainClock or negedge ResetN) begin
    if (!ResetN) begin
      state          <= ST_IDLE;
      wait_cnt       <= 3'd0;
      halt_pending   <= 1'b0;
      MemRead        <= 1'b0;
      PcInc          <= 1'b0;
      PcLoad         <= 1'b0;
      LatchInstrReg  <= 1'b0;
      ClearInstrReg  <= 1'b1;
      EnableInstrReg <= 1'b0;
      AccLoad        <= 1'b0;
      AluOp          <= ALU_PASS;
      OutLatch       <= 1'b0;
      Halted         <= 1'b0;
    end else begin
      state <= state_next;

      if ((state_next == ST_FETCH) && (state != ST_FETCH)) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == ST_FETCH) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (state == ST_DECODE) begin
        halt_pending <= dec_ctl.is_halt;
      end

      MemRead       <= (state_next == ST_FETCH) || (state_next == ST_LATCH);
      LatchInstrReg <= (state_next == ST_LATCH);
      PcInc         <= (state_next == ST_LATCH);
      ClearInstrReg <= (state_next == ST_IDLE);
      Halted        <= (state_next == ST_HALT);

      if (state_next == ST_EXEC) begin
        EnableInstrReg <= dec_ctl.enable_ir;
        PcLoad         <= dec_ctl.pc_load;
        AccLoad        <= dec_ctl.acc_load;
        AluOp          <= dec_ctl.alu_op;
        OutLatch       <= dec_ctl.out_latch;
      end else begin
        EnableInstrReg <= EXEC_NONE.enable_ir;
        PcLoad         <= EXEC_NONE.pc_load;
        AccLoad        <= EXEC_NONE.acc_load;
        AluOp          <= EXEC_NONE.alu_op;
        OutLatch       <= EXEC_NONE.out_latch;
      end
    end
  end

  assign StateDbg = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. A main instance uses MEM_WAIT=1; two
// extra instances (MEM_WAIT=0 and 7) share the inputs and are used for the
// latency checks.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int MW = 1;

  logic       MainClock;
  logic       ResetN;
  logic       Run;
  logic [3:0] ToInstr;
  logic       AccZero;

  logic       mem_read, pc_inc, pc_load, latch_ir, clear_ir, enable_ir;
  logic       acc_load, out_latch, halted;
  logic [1:0] alu_op;
  logic [2:0] state_dbg;

  logic [1:0] x_mem_read, x_pc_inc, x_pc_load, x_latch_ir, x_clear_ir;
  logic [1:0] x_enable_ir, x_acc_load, x_out_latch, x_halted;
  logic [1:0] x_alu_op [2];
  logic [2:0] x_state_dbg [2];

  instr_sequencer #(.MEM_WAIT(MW)) dut (
    .MainClock(MainClock), .ResetN(ResetN), .Run(Run), .ToInstr(ToInstr),
    .AccZero(AccZero), .MemRead(mem_read), .PcInc(pc_inc), .PcLoad(pc_load),
    .LatchInstrReg(latch_ir), .ClearInstrReg(clear_ir),
    .EnableInstrReg(enable_ir), .AccLoad(acc_load), .AluOp(alu_op),
    .OutLatch(out_latch), .Halted(halted), .StateDbg(state_dbg)
  );

  instr_sequencer #(.MEM_WAIT(0)) dut_w0 (
    .MainClock(MainClock), .ResetN(ResetN), .Run(Run), .ToInstr(ToInstr),
    .AccZero(AccZero), .MemRead(x_mem_read[0]), .PcInc(x_pc_inc[0]),
    .PcLoad(x_pc_load[0]), .LatchInstrReg(x_latch_ir[0]),
    .ClearInstrReg(x_clear_ir[0]), .EnableInstrReg(x_enable_ir[0]),
    .AccLoad(x_acc_load[0]), .AluOp(x_alu_op[0]), .OutLatch(x_out_latch[0]),
    .Halted(x_halted[0]), .StateDbg(x_state_dbg[0])
  );

  instr_sequencer #(.MEM_WAIT(7)) dut_w7 (
    .MainClock(MainClock), .ResetN(ResetN), .Run(Run), .ToInstr(ToInstr),
    .AccZero(AccZero), .MemRead(x_mem_read[1]), .PcInc(x_pc_inc[1]),
    .PcLoad(x_pc_load[1]), .LatchInstrReg(x_latch_ir[1]),
    .ClearInstrReg(x_clear_ir[1]), .EnableInstrReg(x_enable_ir[1]),
    .AccLoad(x_acc_load[1]), .AluOp(x_alu_op[1]), .OutLatch(x_out_latch[1]),
    .Halted(x_halted[1]), .StateDbg(x_state_dbg[1])
  );

  // Free-running clock, period 10.
  initial begin
    MainClock = 1'b0;
    forever #5 MainClock = ~MainClock;
  end

  // Hard stop in case anything stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic       mem_read;
    logic       pc_inc;
    logic       pc_load;
    logic       latch_ir;
    logic       clear_ir;
    logic       enable_ir;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       out_latch;
    logic       halted;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    logic [3:0] opcode;
    logic       acc_zero;
    logic       drop_run;
    logic       enable;
    logic       pc_load;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       out_latch;
    string      name;
  } vec_t;

  vec_t vectors [12];
  vec_t hlt_vec;

  int vectors_applied;
  int miscompares;

  function automatic obs_t observe();
    obs_t o;
    o.mem_read  = mem_read;
    o.pc_inc    = pc_inc;
    o.pc_load   = pc_load;
    o.latch_ir  = latch_ir;
    o.clear_ir  = clear_ir;
    o.enable_ir = enable_ir;
    o.acc_load  = acc_load;
    o.alu_op    = alu_op;
    o.out_latch = out_latch;
    o.halted    = halted;
    o.state     = state_dbg;
    return o;
  endfunction

  // Expected outputs for the states whose strobes do not depend on opcode.
  function automatic obs_t expect_state(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    case (st)
      3'b000: o.clear_ir = 1'b1;
      3'b001: o.mem_read = 1'b1;
      3'b010: begin
        o.mem_read = 1'b1;
        o.pc_inc   = 1'b1;
        o.latch_ir = 1'b1;
      end
      3'b101: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    vectors_applied++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Runs one instruction starting from a negedge in IDLE or EXEC and checks
  // every cycle: FETCH x(MW+1), LATCH, DECODE, then EXEC strobes.
  task automatic applyStimulus(input vec_t v);
    obs_t want;
    ToInstr = v.opcode;
    AccZero = v.acc_zero;
    Run     = 1'b1;
    for (int k = 0; k < MW + 4; k++) begin
      @(negedge MainClock);
      if (k <= MW) want = expect_state(3'b001);
      else if (k == MW + 1) want = expect_state(3'b010);
      else if (k == MW + 2) want = expect_state(3'b011);
      else begin
        want           = '0;
        want.state     = 3'b100;
        want.enable_ir = v.enable;
        want.pc_load   = v.pc_load;
        want.acc_load  = v.acc_load;
        want.alu_op    = v.alu_op;
        want.out_latch = v.out_latch;
      end
      checkOutput($sformatf("%s cycle %0d", v.name, k), int'(observe()), int'(want));
      if ((k == 0) && v.drop_run) Run = 1'b0;
    end
  endtask

  initial begin
    int cnt_main;
    int cnt_w0;
    int cnt_w7;
    logic found;

    vectors_applied = 0;
    miscompares     = 0;
    ResetN  = 1'b0;
    Run     = 1'b1;
    ToInstr = 4'h0;
    AccZero = 1'b0;

    //              op    az    drop  en    pl    al    alu    ol    name
    vectors[0]  = '{4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, "LDI"};
    vectors[1]  = '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, "ADD"};
    vectors[2]  = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, "SUB"};
    vectors[3]  = '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, "OUT"};
    vectors[4]  = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "JZ az0"};
    vectors[5]  = '{4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "JZ az1"};
    vectors[6]  = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "JMP"};
    vectors[7]  = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "NOP"};
    vectors[8]  = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "op A"};
    vectors[9]  = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "op 7"};
    vectors[10] = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "op E"};
    vectors[11] = '{4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "JMP run drop"};
    hlt_vec     = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "HLT"};

    // Reset held with Run=1, then release: first MemRead one cycle later.
    @(negedge MainClock);
    checkOutput("reset state", int'(observe()), int'(expect_state(3'b000)));
    ResetN = 1'b1;
    @(negedge MainClock);
    checkOutput("first fetch after reset", int'(observe()), int'(expect_state(3'b001)));
    #1 ResetN = 1'b0;
    Run = 1'b0;
    @(negedge MainClock);
    ResetN = 1'b1;

    // Back-to-back instruction stream; the last one drops Run in FETCH.
    foreach (vectors[i]) applyStimulus(vectors[i]);
    @(negedge MainClock);
    checkOutput("idle after run drop", int'(observe()), int'(expect_state(3'b000)));

    // HLT: trapped regardless of Run until reset.
    applyStimulus(hlt_vec);
    @(negedge MainClock);
    checkOutput("enter halt", int'(observe()), int'(expect_state(3'b101)));
    for (int k = 0; k < 20; k++) begin
      Run = ~Run;
      @(negedge MainClock);
      checkOutput($sformatf("halt hold %0d", k), int'(observe()), int'(expect_state(3'b101)));
    end
    ResetN = 1'b0;
    #1;
    checkOutput("reset exits halt", int'(observe()), int'(expect_state(3'b000)));
    @(negedge MainClock);
    ResetN = 1'b1;

    // Latency from FETCH entry to EXEC exit for MEM_WAIT = 1, 0, 7.
    ToInstr  = 4'h0;
    Run      = 1'b1;
    cnt_main = 0;
    cnt_w0   = 0;
    cnt_w7   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge MainClock);
      if (state_dbg != 3'b000) cnt_main++;
      if (x_state_dbg[0] != 3'b000) cnt_w0++;
      if (x_state_dbg[1] != 3'b000) cnt_w7++;
      if (k == 0) Run = 1'b0;
    end
    checkOutput("latency MEM_WAIT=1", cnt_main, 5);
    checkOutput("latency MEM_WAIT=0", cnt_w0, 4);
    checkOutput("latency MEM_WAIT=7", cnt_w7, 11);

    // Reset asserted in the middle of LATCH drops strobes without a clock.
    ToInstr = 4'h1;
    Run     = 1'b1;
    found   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge MainClock);
      if (state_dbg == 3'b010) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach LATCH", int'(found), 1);
    if (found) begin
      checkOutput("strobes in LATCH", int'({latch_ir, pc_inc}), 3);
      #2 ResetN = 1'b0;
      #1;
      checkOutput("async reset in LATCH", int'(observe()), int'(expect_state(3'b000)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
